// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: load formats, default widths
// and the control bundle carried through the memory/write-back alignment stage.
package mips_pkg;

  localparam int DATA_WIDTH_DEFAULT     = 32;
  localparam int REG_ADDR_WIDTH_DEFAULT = 5;

  // Load format codes; any code not listed here is treated as a word load.
  localparam logic [2:0] LT_LB  = 3'b000;
  localparam logic [2:0] LT_LH  = 3'b001;
  localparam logic [2:0] LT_LW  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b100;
  localparam logic [2:0] LT_LHU = 3'b101;

  // Control captured by stage 1, one cycle behind the EX/MEM register.
  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic [2:0] load_type;
  } s1_ctrl_t;

endpackage

// File: rtl/load_extender.sv
// Picks the addressed byte/half/word out of a little-endian memory word,
// sign- or zero-extends it, and flags addresses misaligned for the format.
module load_extender
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            offset,
  input  logic [2:0]            load_type,
  output logic [DATA_WIDTH-1:0] ext_data,
  output logic                  misaligned
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Offset 0 is bits 7:0; halves are chosen by offset[1] alone.
  assign sel_byte = word[{offset, 3'b000} +: 8];
  assign sel_half = word[{offset[1], 4'b0000} +: 16];

  // Format decode: extension of the selected lane plus alignment check.
  always_comb begin
    ext_data   = word;
    misaligned = 1'b0;
    case (load_type)
      LT_LB: begin
        ext_data = {{(DATA_WIDTH-8){sel_byte[7]}}, sel_byte};
      end
      LT_LBU: begin
        ext_data = {{(DATA_WIDTH-8){1'b0}}, sel_byte};
      end
      LT_LH: begin
        ext_data   = {{(DATA_WIDTH-16){sel_half[15]}}, sel_half};
        misaligned = offset[0];
      end
      LT_LHU: begin
        ext_data   = {{(DATA_WIDTH-16){1'b0}}, sel_half};
        misaligned = offset[0];
      end
      default: begin
        ext_data   = word;
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-to-writeback stage. Stage 1 delays the EX/MEM control by one cycle
// so it meets the data memory's registered read word; stage 2 extends the
// load, chooses load vs ALU data and registers the register-file write port.
//
// Flow control: i_valid is a pure step enable shared with the data memory.
// There is no ready; when i_valid is high every stage advances by one
// instruction, when low every register (including outputs) holds and
// i_flush has no effect.
module mem_wb_stage
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEFAULT,
  parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEFAULT
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic                      i_flush,
  input  logic                      i_reg_write,
  input  logic                      i_mem_to_reg,
  input  logic [2:0]                i_load_type,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0]     i_read_data,
  output logic [DATA_WIDTH-1:0]     o_wb_data,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_addr,
  output logic                      o_wb_enable,
  output logic                      o_misaligned
);

  s1_ctrl_t                  s1_ctrl;
  logic [DATA_WIDTH-1:0]     s1_alu;
  logic [REG_ADDR_WIDTH-1:0] s1_rd;

  logic [DATA_WIDTH-1:0]     ext_data;
  logic                      ext_mis;
  logic [DATA_WIDTH-1:0]     wb_data_next;
  logic                      wb_mis_next;
  logic                      wb_en_next;

  load_extender #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extender (
    .word       (i_read_data),
    .offset     (s1_alu[1:0]),
    .load_type  (s1_ctrl.load_type),
    .ext_data   (ext_data),
    .misaligned (ext_mis)
  );

  // Stage 1: align control with the memory's one-cycle read; flush kills the write.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_ctrl <= '0;
      s1_alu  <= '0;
      s1_rd   <= '0;
    end else if (i_valid) begin
      s1_ctrl.reg_write  <= i_reg_write & ~i_flush;
      s1_ctrl.mem_to_reg <= i_mem_to_reg;
      s1_ctrl.load_type  <= i_load_type;
      s1_alu             <= i_alu_result;
      s1_rd              <= i_rd_addr;
    end
  end

  // Stage 2 select: misalignment only matters for loads; $zero is never written.
  always_comb begin
    wb_mis_next  = s1_ctrl.mem_to_reg & ext_mis;
    wb_data_next = s1_ctrl.mem_to_reg ? ext_data : s1_alu;
    wb_en_next   = s1_ctrl.reg_write & ~wb_mis_next & (s1_rd != '0);
  end

  // Stage 2 output register: the register-file write port.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wb_data    <= '0;
      o_wb_addr    <= '0;
      o_wb_enable  <= 1'b0;
      o_misaligned <= 1'b0;
    end else if (i_valid) begin
      o_wb_data    <= wb_data_next;
      o_wb_addr    <= s1_rd;
      o_wb_enable  <= wb_en_next;
      o_misaligned <= wb_mis_next;
    end
  end

endmodule
